// File: rtl/cpu_pkg.sv
// Shared definitions for the demonstration CPU: opcodes, instruction
// field layout and the seven-segment hex font.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int PC_W    = 8;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 10;
  localparam int RS_MSB     = 9;
  localparam int RS_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDI = 4'd4,
    OP_BNZ  = 4'd5,
    OP_OUT  = 4'd6,
    OP_HALT = 4'd7
  } opcode_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg7_font(input logic [3:0] nib);
    logic [6:0] pattern;
    case (nib)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit seven-segment driver. Each digit is lit for
// SCAN_DIV clocks; segment and select outputs are registered together.
module seg7_scan
  import cpu_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] hex_word,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  seg_data_pin,
  output logic [7:0]  seg_cs_pin
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       digit_idx;
  logic             scan_wrap;
  logic [2:0]       next_idx;
  logic [3:0]       next_nib;

  assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign next_idx  = scan_wrap ? digit_idx + 3'd1 : digit_idx;
  assign next_nib  = hex_word[{next_idx, 2'b00} +: 4];

  // Advance the dwell counter and digit index; refresh the segment pattern
  // every clock so content changes appear without waiting for the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt     <= '0;
      digit_idx    <= 3'd0;
      seg_cs_pin   <= 8'hFE;
      seg_data_pin <= 8'hC0;
    end else begin
      scan_cnt     <= scan_wrap ? '0 : scan_cnt + CNT_W'(1);
      digit_idx    <= next_idx;
      seg_cs_pin   <= ~(8'h01 << next_idx);
      seg_data_pin <= {~dp_mask[next_idx], seg7_font(next_nib)};
    end
  end

endmodule

// File: rtl/cpu_top.sv
// Minimal 16-bit single-cycle CPU running a fixed ROM program (sum 1..10),
// with its output register and PC shown on the seven-segment display.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int ROM_DEPTH = 16
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  output logic [15:0] Flag,
  output logic [7:0]  seg_data_pin,
  output logic [7:0]  seg_cs_pin
);

  logic [PC_W-1:0]   pc;
  logic              halted;
  logic [DATA_W-1:0] regs [4];

  logic [15:0]       instr;
  logic [3:0]        opcode;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] imm_sext;

  // Program ROM; anything past the populated depth reads as HALT.
  always_comb begin
    instr = 16'h7000;
    if (int'(pc) < ROM_DEPTH) begin
      case (pc)
        8'd0: instr = 16'h100A;
        8'd1: instr = 16'h1400;
        8'd2: instr = 16'h2400;
        8'd3: instr = 16'h40FF;
        8'd4: instr = 16'h5002;
        8'd5: instr = 16'h6400;
        default: instr = 16'h7000;
      endcase
    end
  end

  assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign imm      = instr[IMM_MSB:IMM_LSB];
  assign rd_val   = regs[rd];
  assign rs_val   = regs[rs];
  assign imm_sext = {{(DATA_W - 8){imm[7]}}, imm};

  // Retire one instruction per clock until HALT freezes the core.
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      pc     <= '0;
      halted <= 1'b0;
      Flag   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (!halted) begin
      pc <= pc + PC_W'(1);
      case (opcode)
        OP_LDI:  regs[rd] <= {8'h00, imm};
        OP_ADD:  regs[rd] <= rd_val + rs_val;
        OP_SUB:  regs[rd] <= rd_val - rs_val;
        OP_ADDI: regs[rd] <= rd_val + imm_sext;
        OP_BNZ:  if (rd_val != '0) pc <= imm;
        OP_OUT:  Flag <= rd_val;
        OP_HALT: begin
          halted <= 1'b1;
          pc     <= pc;
        end
        default: ;
      endcase
    end
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk         (CLK100MHZ),
    .rst_n       (rst),
    .hex_word    ({4'h0, 3'b000, halted, pc, Flag}),
    .dp_mask     (8'h80),
    .seg_data_pin(seg_data_pin),
    .seg_cs_pin  (seg_cs_pin)
  );

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: reset state, program timing, halt
// freeze, display scan sequence and asynchronous mid-run reset.
module tb_cpu_top;

  logic        CLK100MHZ = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Flag;
  logic [7:0]  seg_data_pin;
  logic [7:0]  seg_cs_pin;

  int assert_count = 0;
  int fail_count   = 0;
  logic monitor_on = 1'b0;

  logic [15:0] flag_q [$];
  logic [15:0] disp_q [$];

  logic [7:0] font8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  cpu_top #(
    .SCAN_DIV (2),
    .ROM_DEPTH(16)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .rst         (rst),
    .Flag        (Flag),
    .seg_data_pin(seg_data_pin),
    .seg_cs_pin  (seg_cs_pin)
  );

  // 100 MHz board clock.
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Exactly one digit select must be active on every cycle.
  always @(negedge CLK100MHZ) begin
    if (monitor_on) begin
      assert_count++;
      if ($countones(~seg_cs_pin) != 1 || $isunknown(seg_cs_pin)) begin
        fail_count++;
        $display("[TB] FAIL cs_onehot at %0t: got %h, need exactly one low bit", $time, seg_cs_pin);
      end
    end
  end

  // Hard stop in case something never returns.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge CLK100MHZ);
    #1;
    assert_count++;
    if (Flag !== 16'h0000) begin
      fail_count++; $display("[TB] FAIL reset_flag: got %h need 0000", Flag);
    end
    assert_count++;
    if (seg_cs_pin !== 8'hFE) begin
      fail_count++; $display("[TB] FAIL reset_cs: got %h need FE", seg_cs_pin);
    end
    assert_count++;
    if (seg_data_pin !== 8'hC0) begin
      fail_count++; $display("[TB] FAIL reset_data: got %h need C0", seg_data_pin);
    end
    assert_count++;
    if (dut.pc !== 8'd0 || dut.halted !== 1'b0) begin
      fail_count++; $display("[TB] FAIL reset_pc: got pc=%0d halted=%b need 0/0", dut.pc, dut.halted);
    end
    monitor_on = 1'b1;
  endtask

  // Release reset and check Flag edge by edge through OUT and HALT.
  task automatic test_program(input string tag);
    logic [15:0] exp;
    @(negedge CLK100MHZ);
    rst = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      flag_q.push_back((e >= 33) ? 16'h0037 : 16'h0000);
      @(posedge CLK100MHZ);
      #1;
      exp = flag_q.pop_front();
      assert_count++;
      if (Flag !== exp) begin
        fail_count++;
        $display("[TB] FAIL %s_flag_edge%0d: got %h need %h", tag, e, Flag, exp);
      end
    end
    assert_count++;
    if (dut.pc !== 8'd6 || dut.halted !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL %s_halt: got pc=%0d halted=%b need 6/1", tag, dut.pc, dut.halted);
    end
  endtask

  task automatic test_halt_stable();
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK100MHZ);
      #1;
      assert_count++;
      if (Flag !== 16'h0037 || dut.pc !== 8'd6 || dut.halted !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL halt_stable_c%0d: got flag=%h pc=%0d halted=%b need 0037/6/1",
                 c, Flag, dut.pc, dut.halted);
      end
    end
  endtask

  // Walk two full scan rounds after halt and compare each digit slot.
  task automatic test_display();
    logic [31:0] word;
    logic [7:0]  prev;
    logic [7:0]  exp_cs;
    logic [7:0]  exp_data;
    logic [15:0] exp;
    int waited;
    int d;
    word = {4'h0, 4'h1, 8'h06, 16'h0037};
    waited = 0;
    while (seg_cs_pin !== 8'h7F && waited < 40) begin
      @(negedge CLK100MHZ);
      waited++;
    end
    assert_count++;
    if (seg_cs_pin !== 8'h7F) begin
      fail_count++; $display("[TB] FAIL scan_sync: got %h need 7F", seg_cs_pin);
    end
    prev = seg_cs_pin;
    for (int slot = 0; slot < 16; slot++) begin
      d = slot % 8;
      exp_cs = ~(8'h01 << d);
      exp_data = font8[word[d*4 +: 4]];
      if (d == 7) exp_data = exp_data & 8'h7F;
      disp_q.push_back({exp_cs, exp_data});
      waited = 0;
      do begin
        @(negedge CLK100MHZ);
        waited++;
      end while (seg_cs_pin === prev && waited < 8);
      prev = seg_cs_pin;
      exp = disp_q.pop_front();
      assert_count++;
      if ({seg_cs_pin, seg_data_pin} !== exp) begin
        fail_count++;
        $display("[TB] FAIL scan_digit%0d: got cs=%h data=%h need cs=%h data=%h",
                 d, seg_cs_pin, seg_data_pin, exp[15:8], exp[7:0]);
      end
      if (slot > 0) begin
        assert_count++;
        if (waited != 2) begin
          fail_count++;
          $display("[TB] FAIL scan_period%0d: got %0d cycles need 2", slot, waited);
        end
      end
    end
  endtask

  // Reset mid-loop, check the asynchronous clear, hold, then rerun.
  task automatic test_mid_reset();
    @(negedge CLK100MHZ);
    rst = 1'b0;
    @(negedge CLK100MHZ);
    rst = 1'b1;
    repeat (20) @(posedge CLK100MHZ);
    #1;
    rst = 1'b0;
    #1;
    assert_count++;
    if (dut.pc !== 8'd0 || Flag !== 16'h0000) begin
      fail_count++;
      $display("[TB] FAIL async_reset: got pc=%0d flag=%h need 0/0000", dut.pc, Flag);
    end
    assert_count++;
    if (seg_cs_pin !== 8'hFE || seg_data_pin !== 8'hC0) begin
      fail_count++;
      $display("[TB] FAIL async_reset_disp: got cs=%h data=%h need FE/C0", seg_cs_pin, seg_data_pin);
    end
    repeat (6) @(posedge CLK100MHZ);
    #1;
    assert_count++;
    if (dut.pc !== 8'd0 || dut.regs[0] !== 16'h0000 || dut.regs[1] !== 16'h0000 ||
        dut.halted !== 1'b0 || seg_cs_pin !== 8'hFE) begin
      fail_count++;
      $display("[TB] FAIL reset_hold: got pc=%0d r0=%h r1=%h halted=%b cs=%h need 0/0000/0000/0/FE",
               dut.pc, dut.regs[0], dut.regs[1], dut.halted, seg_cs_pin);
    end
    test_program("rerun");
  endtask

  initial begin
    $display("[TB] starting cpu_top bench");
    test_reset();
    test_program("run");
    test_halt_stable();
    test_display();
    test_mid_reset();
    monitor_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
